// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: rising-edge capture into a pending register,
// software mask, fixed lowest-index-wins priority, one-cycle request to the core
// at an instruction boundary, and an EOI handshake that blocks nesting.
module irq_arbiter #(
  parameter int unsigned N_SRC   = 8,
  parameter logic [15:0] SR_BASE = 16'h0020
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             sr_ie,
  input  logic [15:0]      sr_sel,
  input  logic [15:0]      sr_in,
  output logic [15:0]      sr_out,
  input  logic             irq_en,
  input  logic             boundary,
  output logic             irq_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, REQ, FIRE, SERVICE} state_t;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t           state, state_nx;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_oh;
  logic [N_SRC-1:0] win_clr;
  logic [3:0]       win_idx;
  logic [3:0]       vec_idx;
  logic             vec_valid;
  logic             irq_q;
  logic             fire;
  logic             wr_mask;
  logic             wr_pend;
  logic             wr_eoi;

  // Register-bus write decode and edge detection.
  always_comb begin
    wr_mask = sr_ie && (sr_sel == SR_BASE);
    wr_pend = sr_ie && (sr_sel == SR_BASE + 16'd1);
    wr_eoi  = sr_ie && (sr_sel == SR_BASE + 16'd3);
    w1c     = wr_pend ? sr_in[N_SRC-1:0] : '0;
    rise    = src & ~src_q;
  end

  // Priority pick: isolate the lowest set eligible bit, then encode it.
  always_comb begin
    eligible = pend & mask;
    win_oh   = eligible & (~eligible + ONE);
    win_idx  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (win_oh[i]) win_idx = 4'(i);
    end
  end

  // Next-state logic; fire marks the REQ->FIRE edge.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    case (state)
      IDLE:    if (eligible != '0) state_nx = REQ;
      REQ: begin
        if (eligible == '0) begin
          state_nx = IDLE;
        end else if (irq_en && boundary) begin
          state_nx = FIRE;
          fire     = 1'b1;
        end
      end
      FIRE:    state_nx = SERVICE;
      SERVICE: if (wr_eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The winner clear is applied before OR-ing in rise, so a same-cycle
    // new edge on the winning line stays pending.
    win_clr = fire ? win_oh : '0;
  end

  // State, request pulse and in-service vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_q     <= 1'b0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
    end else begin
      state <= state_nx;
      irq_q <= fire;
      if (fire) begin
        vec_valid <= 1'b1;
        vec_idx   <= win_idx;
      end else if (state == SERVICE && wr_eoi) begin
        vec_valid <= 1'b0;
      end
    end
  end

  // Edge history, pending capture (set beats clear) and software mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '1;
      pend  <= '0;
      mask  <= '0;
    end else begin
      src_q <= src;
      pend  <= (pend & ~w1c & ~win_clr) | rise;
      if (wr_mask) mask <= sr_in[N_SRC-1:0];
    end
  end

  // Read-data decode; EOI and out-of-range addresses read zero.
  always_comb begin
    sr_out = '0;
    if (sr_sel == SR_BASE)              sr_out = 16'(mask);
    else if (sr_sel == SR_BASE + 16'd1) sr_out = 16'(pend);
    else if (sr_sel == SR_BASE + 16'd2) sr_out = {vec_valid, 11'b0, vec_idx};
  end

  assign irq_out = irq_q;
  assign busy    = (state == FIRE) || (state == SERVICE);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a cycle table for the basic fire/EOI flows
// plus hand-written sequences for masking, enable gating, absorption and reset.
module tb_irq_arbiter;

  localparam logic [15:0] A_MASK = 16'h0020;
  localparam logic [15:0] A_PEND = 16'h0021;
  localparam logic [15:0] A_VEC  = 16'h0022;
  localparam logic [15:0] A_EOI  = 16'h0023;
  localparam logic [15:0] A_NONE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        sr_ie = 1'b0;
  logic [15:0] sr_sel = '0;
  logic [15:0] sr_in = '0;
  logic [15:0] sr_out;
  logic        irq_en = 1'b1;
  logic        boundary = 1'b1;
  logic        irq_out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  irq_arbiter #(.N_SRC(8), .SR_BASE(16'h0020)) dut (
    .clk(clk), .rst(rst), .src(src), .sr_ie(sr_ie), .sr_sel(sr_sel),
    .sr_in(sr_in), .sr_out(sr_out), .irq_en(irq_en), .boundary(boundary),
    .irq_out(irq_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ie;
    logic [15:0] sel;
    logic [15:0] din;
    logic [7:0]  s;
    logic        exp_irq;
    logic        exp_busy;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge; outputs are then
  // stable and reflect all prior rising edges.
  task automatic apply(input logic ie, input logic [15:0] sel, input logic [15:0] din,
                       input logic [7:0] s, input logic en, input logic bnd);
    @(negedge clk);
    sr_ie = ie; sr_sel = sel; sr_in = din; src = s; irq_en = en; boundary = bnd;
    #1;
  endtask

  initial begin
    int got;
    int pulses;

    // Write MASK=1, pulse src[0], fire, EOI.
    tbl[0]  = '{1'b1, A_MASK, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, A_MASK, 16'h0000, 8'h01, 1'b0, 1'b0, 16'h0001};
    tbl[2]  = '{1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0001};
    tbl[3]  = '{1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0001};
    tbl[4]  = '{1'b0, A_VEC,  16'h0000, 8'h00, 1'b1, 1'b1, 16'h8000};
    tbl[5]  = '{1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000};
    tbl[6]  = '{1'b0, A_VEC,  16'h0000, 8'h00, 1'b0, 1'b1, 16'h8000};
    tbl[7]  = '{1'b1, A_EOI,  16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, A_VEC,  16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000};
    // MASK=0xFF, src[5] and src[2] together: 2 first, 5 after EOI.
    tbl[9]  = '{1'b1, A_MASK, 16'h00FF, 8'h00, 1'b0, 1'b0, 16'h0001};
    tbl[10] = '{1'b0, A_MASK, 16'h0000, 8'h24, 1'b0, 1'b0, 16'h00FF};
    tbl[11] = '{1'b0, A_PEND, 16'h0000, 8'h24, 1'b0, 1'b0, 16'h0024};
    tbl[12] = '{1'b0, A_PEND, 16'h0000, 8'h24, 1'b0, 1'b0, 16'h0024};
    tbl[13] = '{1'b0, A_VEC,  16'h0000, 8'h24, 1'b1, 1'b1, 16'h8002};
    tbl[14] = '{1'b0, A_PEND, 16'h0000, 8'h24, 1'b0, 1'b1, 16'h0020};
    tbl[15] = '{1'b1, A_EOI,  16'h0000, 8'h24, 1'b0, 1'b1, 16'h0000};
    tbl[16] = '{1'b0, A_PEND, 16'h0000, 8'h24, 1'b0, 1'b0, 16'h0020};
    tbl[17] = '{1'b0, A_VEC,  16'h0000, 8'h24, 1'b0, 1'b0, 16'h0002};
    tbl[18] = '{1'b0, A_VEC,  16'h0000, 8'h24, 1'b1, 1'b1, 16'h8005};
    tbl[19] = '{1'b1, A_EOI,  16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000};
    tbl[20] = '{1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000};

    // Reset state.
    #2;
    chk("rst_irq", {15'b0, irq_out}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    sr_sel = A_MASK; #1; chk("rst_mask", sr_out, 16'h0000);
    sr_sel = A_PEND; #1; chk("rst_pend", sr_out, 16'h0000);
    sr_sel = A_VEC;  #1; chk("rst_vec", sr_out, 16'h0000);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].ie, tbl[i].sel, tbl[i].din, tbl[i].s, 1'b1, 1'b1);
      chk($sformatf("tbl%0d_irq", i), {15'b0, irq_out}, {15'b0, tbl[i].exp_irq});
      chk($sformatf("tbl%0d_busy", i), {15'b0, busy}, {15'b0, tbl[i].exp_busy});
      chk($sformatf("tbl%0d_rd", i), sr_out, tbl[i].exp_rd);
    end

    // Masked source stays pending; unmasking fires within 3 cycles.
    apply(1'b1, A_MASK, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h08, 1'b1, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("mask_pend", sr_out, 16'h0008);
    chk("mask_noirq", {15'b0, irq_out}, 16'h0000);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("mask_nobusy", {15'b0, busy}, 16'h0000);
    apply(1'b1, A_MASK, 16'h0008, 8'h00, 1'b1, 1'b1);
    got = 0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
      if (irq_out) begin
        got = 1;
        chk("unmask_vec", sr_out, 16'h8003);
        break;
      end
    end
    chk("unmask_fired", 16'(got), 16'd1);
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_NONE, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("unmask_done_busy", {15'b0, busy}, 16'h0000);

    // irq_en and boundary gate the request; W1C withdraws it.
    apply(1'b1, A_MASK, 16'h0002, 8'h02, 1'b0, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b1);
    chk("en_pend", sr_out, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b1);
      chk($sformatf("en0_noirq%0d", k), {15'b0, irq_out | busy}, 16'h0000);
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b0);
      chk($sformatf("bnd0_noirq%0d", k), {15'b0, irq_out | busy}, 16'h0000);
    end
    apply(1'b1, A_PEND, 16'h0002, 8'h00, 1'b0, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b0, 1'b1);
    chk("w1c_pend", sr_out, 16'h0000);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
      if (irq_out || busy) pulses++;
    end
    chk("w1c_no_fire", 16'(pulses), 16'd0);

    // Two edges during SERVICE collapse to one pending request.
    apply(1'b1, A_MASK, 16'h0001, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("svc_fire", {15'b0, irq_out}, 16'h0001);
    chk("svc_vec", sr_out, 16'h8000);
    apply(1'b0, A_PEND, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("svc_pend", sr_out, 16'h0001);
    chk("svc_busy", {15'b0, busy}, 16'h0001);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
      if (irq_out) pulses++;
    end
    chk("svc_no_nest", 16'(pulses), 16'd0);
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
      if (irq_out) pulses++;
    end
    chk("svc_one_pulse", 16'(pulses), 16'd1);
    chk("svc_vec2", sr_out, 16'h8000);
    apply(1'b0, A_PEND, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("svc_pend_clr", sr_out, 16'h0000);
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);

    // EOI in IDLE and in FIRE is ignored.
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("eoi_idle_vec", sr_out, 16'h0000);
    chk("eoi_idle_busy", {15'b0, busy}, 16'h0000);
    apply(1'b0, A_VEC, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("eoi_fire_irq", {15'b0, irq_out}, 16'h0001);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("eoi_fire_busy", {15'b0, busy}, 16'h0001);
    chk("eoi_fire_vec", sr_out, 16'h8000);
    apply(1'b1, A_EOI, 16'h0000, 8'h00, 1'b1, 1'b1);
    apply(1'b0, A_VEC, 16'h0000, 8'h00, 1'b1, 1'b1);
    chk("eoi_svc_busy", {15'b0, busy}, 16'h0000);

    // Asynchronous reset during FIRE with src held high across it.
    apply(1'b0, A_NONE, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_NONE, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_NONE, 16'h0000, 8'h01, 1'b1, 1'b1);
    apply(1'b0, A_NONE, 16'h0000, 8'h01, 1'b1, 1'b1);
    chk("pre_rst_irq", {15'b0, irq_out}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("rst_fire_irq", {15'b0, irq_out}, 16'h0000);
    chk("rst_fire_busy", {15'b0, busy}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, A_PEND, 16'h0000, 8'h01, 1'b1, 1'b1);
      chk($sformatf("post_rst_pend%0d", k), sr_out, 16'h0000);
    end
    apply(1'b0, A_MASK, 16'h0000, 8'h01, 1'b1, 1'b1);
    chk("post_rst_mask", sr_out, 16'h0000);
    apply(1'b0, A_VEC, 16'h0000, 8'h01, 1'b1, 1'b1);
    chk("post_rst_vec", sr_out, 16'h0000);
    apply(1'b1, A_MASK, 16'h0001, 8'h01, 1'b1, 1'b1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, A_NONE, 16'h0000, 8'h01, 1'b1, 1'b1);
      if (irq_out || busy) pulses++;
    end
    chk("post_rst_no_req", 16'(pulses), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got stall expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt controller in front of the special-register block's single `irq_in`.
- Captures rising edges from N_SRC peripheral lines into a pending register and applies a software mask.
- Picks the highest-priority source and issues a one-cycle interrupt request to the core at an instruction boundary, while CPU interrupts are enabled.
- Blocks further requests until software writes end-of-interrupt (EOI). Mask, pending, vector and EOI are accessed through the special-register bus.

Parameters:
- N_SRC, 8: number of interrupt sources (1..15).
- SR_BASE, 16'h0020: first special-register address used by this block; the block occupies SR_BASE..SR_BASE+3.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- src  input  N_SRC  interrupt lines, synchronous to clk, level; a rising edge raises the request
- sr_ie  input  1  special-register write enable
- sr_sel  input  16  special-register address
- sr_in  input  16  special-register write data
- sr_out  output  16  read data; combinational decode of sr_sel
- irq_en  input  1  CPU interrupt-enable flag from the special-register block
- boundary  input  1  instruction boundary; core asserts it when the pc loads or increments
- irq_out  output  1  interrupt request to core `irq_in`; registered
- busy  output  1  high in states FIRE and SERVICE

Behaviour:
- Register map:
  - SR_BASE+0 MASK, read/write. Bit i=1 enables source i. Reset 0, i.e. all sources masked.
  - SR_BASE+1 PEND, read. A write with bit i=1 clears pending bit i (write-1-to-clear).
  - SR_BASE+2 VEC, read-only. [15]=in-service valid, [3:0]=latched source index, other bits 0.
  - SR_BASE+3 EOI, write-only; any data value is accepted.
- sr_out returns 0 for EOI and for any address outside the block's range. Writes to unused MASK/PEND bits (>= N_SRC) are ignored; those bits read 0.
- Edge capture:
  - src_q <= src every cycle; rise = src & ~src_q.
  - At each edge, pend <= (pend & ~w1c) | rise.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
  - src already high out of reset does not count as an edge: src_q resets to all-ones.
- Priority: eligible = pend & MASK. The lowest set index wins.
- FSM states: IDLE, REQ, FIRE, SERVICE. Reset state IDLE.
  - IDLE -> REQ when eligible != 0.
  - REQ -> IDLE when eligible == 0, e.g. the mask or W1C removed the request.
  - REQ -> FIRE when irq_en & boundary & eligible != 0. On this edge:
    - latch the winner into VEC[3:0], set VEC[15]=1;
    - clear the winner's pending bit, unless a new rise arrives on that bit the same cycle;
    - set irq_out to 1.
  - The winner is re-evaluated every cycle in REQ, so a higher-priority arrival before firing displaces a lower one.
  - FIRE -> SERVICE unconditionally; irq_out returns to 0, so irq_out is exactly 1 cycle wide.
  - SERVICE -> IDLE on a write to EOI. VEC[15] clears; VEC[3:0] holds its last value.
  - EOI writes in other states are ignored.
- No nesting: pending edges accumulate during FIRE/SERVICE and are arbitrated after EOI.
- Latency: a src rise sampled at edge k gives pend set after edge k. REQ follows after edge k+1. With irq_en and boundary already high, FIRE (irq_out=1) follows after edge k+2.
- A second rise on a source that is already pending is absorbed; there is no counting.
- Reset: asynchronous reset at any point, including mid-FIRE, immediately forces:
  - irq_out=0, busy=0, state IDLE;
  - pend=0, MASK=0, VEC=0, src_q all-ones.
- Outputs in reset: irq_out 0, busy 0, sr_out 0 for any sr_sel except MASK/PEND/VEC, which read 0.

Test Plan:
- MASK=0x01; pulse src[0] with irq_en=1, boundary=1 -> irq_out high for exactly one cycle, 2 cycles after pend[0] is set. VEC reads 0x8000, PEND reads 0x00, busy=1 until an EOI write, then VEC[15]=0.
- MASK=0xFF; raise src[5] and src[2] in the same cycle -> fire with VEC=0x8002, PEND=0x20. After EOI a second irq_out pulse gives VEC=0x8005.
- MASK=0x00; pulse src[3] -> PEND=0x08, no irq_out. Write MASK=0x08 -> irq_out pulses within 3 cycles.
- irq_en=0 with pend[1] eligible -> state stays REQ, no irq_out. Write PEND=0x02 -> returns to IDLE. Raise irq_en -> still no pulse.
- In SERVICE, pulse src[0] twice -> PEND=0x01, a single irq_out only after EOI. An EOI write while IDLE has no effect.
- Assert rst during FIRE -> irq_out drops immediately. After release, MASK=PEND=VEC=0, and src held high from before reset raises no request.
